// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retirement trace buffer.
// Record field widths are fixed here; the top-level XLEN/ORDER_W defaults must match them.
package retire_trace_pkg;

   localparam int TRACE_XLEN    = 32;
   localparam int TRACE_ORDER_W = 64;
   localparam int PC_STEP       = 4;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [TRACE_ORDER_W-1:0] order;
      logic [TRACE_XLEN-1:0]    pc;
      logic [31:0]              inst;
      logic [TRACE_XLEN-1:0]    rs1_val;
      logic [TRACE_XLEN-1:0]    rs2_val;
      logic [4:0]               rd;
      logic                     rd_we;
      logic [TRACE_XLEN-1:0]    rd_wdata;
   } retire_rec_t;

endpackage

// File: rtl/retire_fifo.sv
// Generic synchronous FIFO; full/empty told apart by an extra pointer bit.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module retire_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// Builds ordered retirement records from the WB stream and queues them for a checker.
// Define RETIRE_TRACE_PC_CHECK_EN to enable the sticky PC-continuity check on pc_err.
module retire_trace_buffer
   import retire_trace_pkg::*;
#(
   parameter int          XLEN    = TRACE_XLEN,
   parameter int          DEPTH   = 8,
   parameter int          ORDER_W = TRACE_ORDER_W,
   parameter logic [31:0] PC_INIT = 32'h200
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic [31:0]              wb_inst,
   input  logic                     wb_we,
   input  logic [4:0]               wb_rd,
   input  logic [XLEN-1:0]          wb_value,
   output logic                     out_valid,
   input  logic                     out_ready,
   output retire_rec_t              out_rec,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     pc_err
);

   logic [XLEN-1:0]    shadow [32];
   logic [ORDER_W-1:0] order_cnt;
   retire_rec_t        rec;
   retire_rec_t        head;
   logic               fifo_full;
   logic               fifo_empty;

   // Operands come from the shadow file before this cycle's write lands.
   always_comb begin
      rec          = '0;
      rec.order    = order_cnt;
      rec.pc       = wb_pc;
      rec.inst     = wb_inst;
      rec.rs1_val  = shadow[wb_inst[19:15]];
      rec.rs2_val  = shadow[wb_inst[24:20]];
      rec.rd       = wb_rd;
      rec.rd_we    = wb_we && (wb_rd != 5'd0);
      rec.rd_wdata = rec.rd_we ? wb_value : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) shadow[i] <= '0;
         order_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (wb_valid) begin
            order_cnt <= order_cnt + 1'b1;
            if (rec.rd_we) shadow[wb_rd] <= wb_value;
            if (fifo_full && !out_ready) overflow <= 1'b1;
         end
      end
   end

   retire_fifo #(
      .WIDTH ($bits(retire_rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wb_valid),
      .wdata (rec),
      .pop   (out_ready),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign out_valid = !fifo_empty;
   assign out_rec   = out_valid ? head : '0;

`ifdef RETIRE_TRACE_PC_CHECK_EN
   logic [XLEN-1:0] expected_pc;
   logic            skip_check;
   logic            ctrl_xfer;

   assign ctrl_xfer = (wb_inst[6:0] == OPC_JAL) || (wb_inst[6:0] == OPC_JALR) ||
                      (wb_inst[6:0] == OPC_BRANCH);

   // After a jump or branch the target is unknown, so the next retirement re-seeds the expectation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         expected_pc <= XLEN'(PC_INIT);
         skip_check  <= 1'b0;
         pc_err      <= 1'b0;
      end else if (wb_valid) begin
         if (!skip_check && (wb_pc != expected_pc)) pc_err <= 1'b1;
         skip_check  <= ctrl_xfer;
         expected_pc <= wb_pc + XLEN'(PC_STEP);
      end
   end
`else
   assign pc_err = 1'b0;
`endif

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: expected records queued at retire, compared at pop.
module tb_retire_trace_buffer;
   import retire_trace_pkg::*;

   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wb_valid = 1'b0;
   logic [31:0]       wb_pc = '0;
   logic [31:0]       wb_inst = '0;
   logic              wb_we = 1'b0;
   logic [4:0]        wb_rd = '0;
   logic [31:0]       wb_value = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   retire_rec_t       out_rec;
   logic [3:0]        count;
   logic              overflow;
   logic              pc_err;

   int checks = 0;
   int passes = 0;

   retire_rec_t sb[$];
   logic [31:0] model_regs [32];
   logic [63:0] model_order;
   int          model_count;

   retire_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_value(wb_value), .out_valid(out_valid),
      .out_ready(out_ready), .out_rec(out_rec), .count(count), .overflow(overflow),
      .pc_err(pc_err)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      model_order = '0;
      model_count = 0;
      sb.delete();
   endtask

   // One clock: drive at negedge, check/pop the head before the edge, model the push.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic we, input logic [4:0] rd, input logic [31:0] val,
                        input logic rdy);
      retire_rec_t exp;
      logic pop_m;
      @(negedge clk);
      wb_valid = v; wb_pc = pc; wb_inst = inst; wb_we = we; wb_rd = rd; wb_value = val;
      out_ready = rdy;
      #1;
      checks++;
      if (out_valid !== (model_count != 0))
         $display("FAIL out_valid: got %b want %b", out_valid, (model_count != 0));
      else passes++;
      pop_m = rdy && (model_count != 0);
      if (pop_m) begin
         checks++;
         if (sb.size() == 0) $display("FAIL pop_record: scoreboard empty");
         else begin
            exp = sb.pop_front();
            if (out_rec !== exp)
               $display("FAIL pop_record: got %h want %h", out_rec, exp);
            else passes++;
         end
      end
      if (v) begin
         exp          = '0;
         exp.order    = model_order;
         exp.pc       = pc;
         exp.inst     = inst;
         exp.rs1_val  = model_regs[inst[19:15]];
         exp.rs2_val  = model_regs[inst[24:20]];
         exp.rd       = rd;
         exp.rd_we    = we && (rd != 5'd0);
         exp.rd_wdata = exp.rd_we ? val : 32'd0;
         model_order  = model_order + 1;
         if (model_count < DEPTH || pop_m) begin
            sb.push_back(exp);
            model_count++;
         end
         if (exp.rd_we) model_regs[rd] = val;
      end
      if (pop_m) model_count--;
      @(posedge clk); #1;
      wb_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passes++;
      checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passes++;
      checks++; if (pc_err !== 1'b0) $display("FAIL reset_pc_err: got %b want 0", pc_err); else passes++;
      checks++; if (out_rec !== '0) $display("FAIL reset_rec: got %h want 0", out_rec); else passes++;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_operands();
      test_reset();
      cycle(1, 32'h200, 32'h00500093, 1, 5'd1, 32'd5, 0);
      checks++;
      if (out_valid !== 1'b1 || out_rec.order !== 64'd0 || out_rec.pc !== 32'h200 ||
          out_rec.rs1_val !== 32'd0 || out_rec.rd_we !== 1'b1 || out_rec.rd_wdata !== 32'd5)
         $display("FAIL first_record: got v=%b %h", out_valid, out_rec);
      else passes++;
      cycle(1, 32'h204, 32'h00108133, 1, 5'd2, 32'd10, 1);
      cycle(1, 32'h208, 32'h00108093, 1, 5'd1, 32'd6, 0);
      checks++;
      if (out_rec.rs1_val !== 32'd5 || out_rec.rs2_val !== 32'd5)
         $display("FAIL add_operands: got rs1=%h rs2=%h want 5 5", out_rec.rs1_val, out_rec.rs2_val);
      else passes++;
      cycle(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (out_rec.rs1_val !== 32'd5) $display("FAIL own_rd_old: got %h want 5", out_rec.rs1_val);
      else passes++;
      cycle(1, 32'h20c, 32'h000081b3, 1, 5'd3, 32'd6, 0);
      drain();
   endtask

   task automatic test_x0();
      cycle(1, 32'h210, 32'h00000013, 1, 5'd0, 32'hDEADBEEF, 0);
      checks++;
      if (out_rec.rd_we !== 1'b0 || out_rec.rd_wdata !== 32'd0)
         $display("FAIL x0_write: got we=%b wdata=%h want 0 0", out_rec.rd_we, out_rec.rd_wdata);
      else passes++;
      cycle(0, 0, 0, 1, 5'd4, 32'h55, 0);
      cycle(1, 32'h214, 32'h00400233, 1, 5'd5, 32'd0, 1);
      cycle(1, 32'h218, 32'h00020313, 1, 5'd6, 32'd1, 1);
      drain();
   endtask

   task automatic test_overflow();
      test_reset();
      for (int i = 0; i < DEPTH + 1; i++)
         cycle(1, 32'h200 + 4 * i, 32'h00108093, 1, 5'd1, i, 0);
      checks++; if (count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", count); else passes++;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passes++;
      drain();
      cycle(1, 32'h300, 32'h00108093, 1, 5'd1, 32'd77, 0);
      checks++;
      if (out_rec.order !== 64'd9) $display("FAIL order_after_drop: got %0d want 9", out_rec.order);
      else passes++;
      drain();
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passes++;
   endtask

   task automatic test_back_to_back();
      test_reset();
      for (int i = 0; i < DEPTH; i++)
         cycle(1, 32'h200 + 4 * i, 32'h00208113, 1, 5'd2, 32'd100 + i, 0);
      for (int i = 0; i < 3; i++)
         cycle(1, 32'h220 + 4 * i, 32'h00110193, 1, 5'd3, 32'd200 + i, 1);
      checks++; if (count !== 4'd8) $display("FAIL full_pushpop_count: got %0d want 8", count); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL full_pushpop_ovf: got %b want 0", overflow); else passes++;
      drain();
      cycle(1, 32'h240, 32'h00000013, 1, 5'd7, 32'd9, 0);
      cycle(1, 32'h244, 32'h00000013, 1, 5'd8, 32'd9, 0);
      test_reset();
      checks++; if (out_valid !== 1'b0) $display("FAIL midstream_reset: got %b want 0", out_valid); else passes++;
      cycle(1, 32'h200, 32'h00700393, 1, 5'd7, 32'd7, 1);
      drain();
   endtask

`ifdef RETIRE_TRACE_PC_CHECK_EN
   task automatic test_pc_check();
      test_reset();
      cycle(1, 32'h200, 32'h00500093, 1, 5'd1, 32'd5, 1);
      cycle(1, 32'h208, 32'h00500093, 1, 5'd1, 32'd5, 1);
      checks++; if (pc_err !== 1'b1) $display("FAIL pc_gap: got %b want 1", pc_err); else passes++;
      drain();
      test_reset();
      cycle(1, 32'h200, 32'h0000006f, 0, 5'd0, 32'd0, 1);
      cycle(1, 32'h400, 32'h00500093, 1, 5'd1, 32'd5, 1);
      cycle(1, 32'h404, 32'h00500093, 1, 5'd1, 32'd5, 1);
      checks++; if (pc_err !== 1'b0) $display("FAIL pc_after_jal: got %b want 0", pc_err); else passes++;
      cycle(1, 32'h40c, 32'h00500093, 1, 5'd1, 32'd5, 1);
      checks++; if (pc_err !== 1'b1) $display("FAIL pc_gap_after_jal: got %b want 1", pc_err); else passes++;
      drain();
   endtask
`endif

   initial begin
      model_clear();
      test_reset();
      test_operands();
      test_x0();
      test_overflow();
      test_back_to_back();
`ifdef RETIRE_TRACE_PC_CHECK_EN
      test_pc_check();
`endif
      checks++;
      if (sb.size() != 0) $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Consumes the write-back-stage retirement stream produced by the pipeline follower (wb_pc, wb_inst, bubble, WB write port) of the RV12 core.
- Turns each retired instruction into an ordered retirement record with source-operand values taken from an internal shadow register file.
- Buffers records in a FIFO drained by a ready/valid consumer (scoreboard or golden ISA model).
- Sits directly downstream of the pipeline follower and upstream of the ISA checkers.

Parameters:
- XLEN, 32, data/PC width.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- ORDER_W, 64, retirement counter width.
- PC_INIT, 32'h200, expected PC of the first retired instruction.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- wb_valid  input  1  a non-bubble instruction retires this cycle.
- wb_pc  input  XLEN  PC of the retiring instruction.
- wb_inst  input  32  encoding of the retiring instruction.
- wb_we  input  1  register-file write enable from WB.
- wb_rd  input  5  destination register index.
- wb_value  input  XLEN  write-back data.
- out_valid  output  1  head record available.
- out_ready  input  1  consumer accepts the head record.
- out_rec  output  $bits(retire_rec_t)  head record.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a record was dropped.
- pc_err  output  1  sticky flag: PC discontinuity (optional feature only; tied to 0 otherwise).

Behaviour:
- Reset (async, active-high):
  - FIFO empty; out_valid=0; count=0; overflow=0; pc_err=0; out_rec=0.
  - Order counter=0.
  - All 32 shadow registers = 0.
- Record built in the retire cycle:
  - order = counter value.
  - pc, inst.
  - rs1_val = shadow[inst[19:15]].
  - rs2_val = shadow[inst[24:20]].
  - rd = wb_rd.
  - rd_we = wb_we && (wb_rd != 0).
  - rd_wdata = rd_we ? wb_value : 0.
- Shadow register update:
  - Operands are read before the same-cycle write, so an instruction reading its own rd sees the old value.
  - shadow[wb_rd] <= wb_value only when wb_valid && rd_we. x0 is never written and always reads 0.
  - wb_we asserted while wb_valid=0 is ignored.
- Order counter:
  - Increments by 1 on every wb_valid, including dropped records.
  - Wraps modulo 2^ORDER_W.
- Latency:
  - Record enters the FIFO at the clock edge ending the retire cycle.
  - out_valid is seen high in the following cycle; first-word latency is 1.
- Handshake:
  - Pop when out_valid && out_ready.
  - out_rec stays stable while out_valid && !out_ready.
  - out_rec is don't-care while out_valid=0 and is driven to 0 after reset.
- Full/empty cases:
  - Push while full with a same-cycle pop: both take effect and count is unchanged.
  - Push while full without a pop: record dropped, overflow set (sticky until reset), FIFO contents untouched.
  - Pop while empty: no effect.
  - Push and pop on an empty FIFO: the new record is enqueued and not bypassed to the output in the same cycle.
- Pointers: wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Reset mid-stream: all buffered records are discarded immediately; no partial handshake survives.

Optional Feature:
- Macro: RETIRE_TRACE_PC_CHECK_EN.
- Enabled:
  - Tracks expected_pc (reset value PC_INIT).
  - On each wb_valid, if wb_pc != expected_pc, pc_err is set (sticky).
  - expected_pc is then updated:
    - If inst[6:0] is JAL (1101111), JALR (1100111) or BRANCH (1100011), the next PC is unknown, so the check for the next retirement is skipped and expected_pc is set from that next wb_pc.
    - Otherwise expected_pc = wb_pc + 4.
- Disabled: pc_err tied to 0, no expected_pc state.

Decomposition:
- Package retire_trace_pkg holds:
  - typedef retire_rec_t (packed struct: order, pc, inst, rs1_val, rs2_val, rd, rd_we, rd_wdata).
  - Opcode constants OPC_JAL, OPC_JALR, OPC_BRANCH.
  - Localparam PC_STEP=4.
- One sub-module, retire_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count.
- Shadow register file and order counter stay in the top module.

Test Plan:
- Reset, then retire addi x1,x0,5 (pc 0x200, inst 0x00500093, we=1, rd=1, value=5) → next cycle out_valid=1 with order=0, pc=0x200, rs1_val=0, rd_we=1, rd_wdata=5.
- Then retire add x2,x1,x1 (0x00108133), value=10 → record has rs1_val=5, rs2_val=5. Then retire addi x1,x1,1 (0x00108093) → record has rs1_val=5 (old value), and shadow x1 becomes 6.
- Retire write to x0 with wb_value=0xDEADBEEF → rd_we=0, rd_wdata=0; a later read of x0 gives rs1_val=0.
- Hold out_ready=0, retire DEPTH+1=9 instructions → count=8, overflow=1, drained orders are 0..7, and the next retirement has order=9.
- FIFO full, out_ready=1 and wb_valid=1 in the same cycle → count stays 8, overflow stays 0, output order stays contiguous.
- With RETIRE_TRACE_PC_CHECK_EN:
  - Retire pc 0x200, then 0x208 → pc_err=1.
  - Separate run: pc 0x200 JAL, then 0x400 → pc_err=0.
